pll_lock_reset_seq: RTL



---
 rtl/pll_lock_reset_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the pll_clk domain: synchronizes and qualifies the PLL lock, then holds and
// releases sys_rst_n. Optional loss-of-lock counter is compiled in with `define PLL_LOSS_COUNT_EN.
module pll_lock_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LOSS_W        = 8
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic              locked,
    output logic              sys_rst_n,
    output logic              ready,
    output logic [1:0]        state,
    output logic [LOSS_W-1:0] loss_cnt
);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q;
    logic             sync1;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    // Outputs are assigned together with the state transition so they move on the same edge.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitLock;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (locked_s) begin
                        state_q <= StStable;
                        cnt     <= '0;
                    end
                end
                StStable: begin
                    if (!locked_s) begin
                        state_q <= StWaitLock;
                        cnt     <= '0;
                    end else if (cnt == StableLast) begin
                        state_q <= StHold;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!locked_s) begin
                        state_q <= StWaitLock;
                        cnt     <= '0;
                    end else if (cnt == HoldLast) begin
                        state_q   <= StRun;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_q   <= StWaitLock;
                        cnt       <= '0;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign state = state_q;

`ifdef PLL_LOSS_COUNT_EN
    // Saturating count of lock losses seen while running.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (state_q == StRun && !locked_s && loss_cnt != {LOSS_W{1'b1}}) begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
        end
    end
`else
    assign loss_cnt = '0;
`endif

endmodule
